// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point pipeline blocks.
// Operand classification, flag bit positions and the canonical quiet NaN.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    localparam int FLAG_W         = 3;
    localparam int FLAG_INVALID   = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    // Positive sign, all-ones exponent, only the fraction MSB set; callers cast to their width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] one;
        one = 64'd1;
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// The master side issues operands and consumes results; the slave is the multiplier.
interface fp_mul_pipe_if
    import fp_pkg::*;
#(
    parameter int W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      x;
    logic [W-1:0]      y;
    logic              rnd_mode;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      result;
    logic [FLAG_W-1:0] flags;

    modport master (
        output in_valid, x, y, rnd_mode, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, x, y, rnd_mode, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_round_pack.sv
// Rounding and packing of a normalised mantissa with guard/round/sticky bits.
// Purely combinational so both the multiplier and the adder pipelines can reuse it.
module fp_round_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                    sign,
    input  logic signed [EXP_W+1:0] exp_in,
    input  logic [MAN_W-1:0]        frac_in,
    input  logic                    guard,
    input  logic                    round,
    input  logic                    sticky,
    input  logic                    trunc,
    output logic [EXP_W+MAN_W:0]    pack_out,
    output logic                    overflow,
    output logic                    underflow
);
    localparam logic signed [EXP_W+1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

    logic                    inc;
    logic [MAN_W:0]          frac_sum;
    logic signed [EXP_W+1:0] exp_adj;

    // A carry out of the fraction leaves it zero and bumps the exponent, so no renormalise is needed.
    always_comb begin
        inc       = !trunc && guard && (round || sticky || frac_in[0]);
        frac_sum  = {1'b0, frac_in} + {{MAN_W{1'b0}}, inc};
        exp_adj   = exp_in + $signed({{(EXP_W+1){1'b0}}, frac_sum[MAN_W]});
        overflow  = 1'b0;
        underflow = 1'b0;
        pack_out  = {sign, exp_adj[EXP_W-1:0], frac_sum[MAN_W-1:0]};
        if (exp_adj >= EXP_MAX) begin
            pack_out = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow = 1'b1;
        end else if (exp_adj <= EXP_ZERO) begin
            pack_out  = {sign, {(EXP_W+MAN_W){1'b0}}};
            underflow = 1'b1;
        end
    end
endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier: unpack/multiply, normalise, round/pack.
// Subnormals flush to zero; a single global stall freezes every stage when the output is blocked.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic          clk,
    input logic          reset_n,
    fp_mul_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [EXP_W+1:0] BIAS_E = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [W-1:0]     QNAN   = W'(fp_qnan(EXP_W, MAN_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0) return FP_ZERO;
        if (e == '1) return (f == '0) ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

    logic advance;

    logic [W-1:0]       x_w, y_w;
    logic               sign_d;
    fp_class_e          cls_x, cls_y;
    logic [PW-1:0]      prod_d;
    logic signed [EXP_W+1:0] exp_d;
    logic               special_d;
    logic [W-1:0]       special_res_d;
    logic [FLAG_W-1:0]  special_flags_d;

    logic               s1_valid, s1_sign, s1_rnd, s1_special;
    logic [PW-1:0]      s1_prod;
    logic signed [EXP_W+1:0] s1_exp;
    logic [W-1:0]       s1_special_res;
    logic [FLAG_W-1:0]  s1_special_flags;

    logic [PW-2:0]      norm;
    logic signed [EXP_W+1:0] norm_exp;

    logic               s2_valid, s2_sign, s2_rnd, s2_special;
    logic [MAN_W-1:0]   s2_frac;
    logic               s2_g, s2_r, s2_s;
    logic signed [EXP_W+1:0] s2_exp;
    logic [W-1:0]       s2_special_res;
    logic [FLAG_W-1:0]  s2_special_flags;

    logic [W-1:0]       rp_result;
    logic               rp_ovf, rp_unf;
    logic [W-1:0]       s3_result;
    logic [FLAG_W-1:0]  s3_flags;

    logic               out_valid_q;
    logic [W-1:0]       result_q;
    logic [FLAG_W-1:0]  flags_q;

    assign advance       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign x_w           = bus.x;
    assign y_w           = bus.y;

    // Stage 1 datapath: classify, multiply hidden-one mantissas, and resolve special operands early.
    always_comb begin
        sign_d = x_w[W-1] ^ y_w[W-1];
        cls_x  = classify(x_w[W-2:MAN_W], x_w[MAN_W-1:0]);
        cls_y  = classify(y_w[W-2:MAN_W], y_w[MAN_W-1:0]);
        prod_d = PW'({1'b1, x_w[MAN_W-1:0]}) * PW'({1'b1, y_w[MAN_W-1:0]});
        exp_d  = $signed({2'b00, x_w[W-2:MAN_W]}) + $signed({2'b00, y_w[W-2:MAN_W]})
               - $signed(BIAS_E);
        special_d       = 1'b1;
        special_res_d   = '0;
        special_flags_d = '0;
        if (cls_x == FP_NAN || cls_y == FP_NAN) begin
            special_res_d = QNAN;
        end else if ((cls_x == FP_ZERO && cls_y == FP_INF) || (cls_x == FP_INF && cls_y == FP_ZERO)) begin
            special_res_d                 = QNAN;
            special_flags_d[FLAG_INVALID] = 1'b1;
        end else if (cls_x == FP_INF || cls_y == FP_INF) begin
            special_res_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_x == FP_ZERO || cls_y == FP_ZERO) begin
            special_res_d = {sign_d, {(W-1){1'b0}}};
        end else begin
            special_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid         <= 1'b0;
            s1_sign          <= 1'b0;
            s1_rnd           <= 1'b0;
            s1_special       <= 1'b0;
            s1_prod          <= '0;
            s1_exp           <= '0;
            s1_special_res   <= '0;
            s1_special_flags <= '0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign          <= sign_d;
                s1_rnd           <= bus.rnd_mode;
                s1_special       <= special_d;
                s1_prod          <= prod_d;
                s1_exp           <= exp_d;
                s1_special_res   <= special_res_d;
                s1_special_flags <= special_flags_d;
            end
        end
    end

    // Align the leading one to the top of 'norm'; a set product MSB means the exponent grows by one.
    always_comb begin
        norm     = s1_prod[PW-1] ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};
        norm_exp = s1_exp + $signed({{(EXP_W+1){1'b0}}, s1_prod[PW-1]});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid         <= 1'b0;
            s2_sign          <= 1'b0;
            s2_rnd           <= 1'b0;
            s2_special       <= 1'b0;
            s2_frac          <= '0;
            s2_g             <= 1'b0;
            s2_r             <= 1'b0;
            s2_s             <= 1'b0;
            s2_exp           <= '0;
            s2_special_res   <= '0;
            s2_special_flags <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign          <= s1_sign;
                s2_rnd           <= s1_rnd;
                s2_special       <= s1_special;
                s2_frac          <= norm[PW-2 -: MAN_W];
                s2_g             <= norm[MAN_W];
                s2_r             <= norm[MAN_W-1];
                s2_s             <= |norm[MAN_W-2:0];
                s2_exp           <= norm_exp;
                s2_special_res   <= s1_special_res;
                s2_special_flags <= s1_special_flags;
            end
        end
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign      (s2_sign),
        .exp_in    (s2_exp),
        .frac_in   (s2_frac),
        .guard     (s2_g),
        .round     (s2_r),
        .sticky    (s2_s),
        .trunc     (s2_rnd),
        .pack_out  (rp_result),
        .overflow  (rp_ovf),
        .underflow (rp_unf)
    );

    always_comb begin
        s3_result                = rp_result;
        s3_flags                 = '0;
        s3_flags[FLAG_OVERFLOW]  = rp_ovf;
        s3_flags[FLAG_UNDERFLOW] = rp_unf;
        if (s2_special) begin
            s3_result = s2_special_res;
            s3_flags  = s2_special_flags;
        end
    end

    // Result and flags only load on a real transfer, so they stay frozen through stalls and bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (advance) begin
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                result_q <= s3_result;
                flags_q  <= s3_flags;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed vectors, streaming with backpressure,
// randomized traffic against an integer-arithmetic reference model, mid-stream reset, half precision.
module tb_fp_mul_pipe;
    typedef longint unsigned u64;

    typedef struct {
        u64       a;
        u64       b;
        bit       rnd;
        u64       res;
        logic [2:0] fl;
    } vec_t;

    logic clk;
    logic reset_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    fp_mul_pipe_if #(.W(32)) bus32 ();
    fp_mul_pipe_if #(.W(16)) bus16 ();

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32));
    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Exact integer product, then rounding decided by comparing the discarded remainder against one half.
    function automatic void ref_mul(input u64 a, input u64 b, input bit rnd, input int ew, input int mw,
                                    output u64 res, output logic [2:0] fl);
        u64 one, maxe, fmask, fa, fb, ea, eb, p, q, rem, half, qnan, sbit;
        int e, sh;
        bit za, zb, ia, ib, na, nb;
        one   = 1;
        maxe  = (one << ew) - 1;
        fmask = (one << mw) - 1;
        fa = a & fmask;          fb = b & fmask;
        ea = (a >> mw) & maxe;   eb = (b >> mw) & maxe;
        sbit = (((a >> (ew + mw)) ^ (b >> (ew + mw))) & one) << (ew + mw);
        za = (ea == 0);                 zb = (eb == 0);
        ia = (ea == maxe && fa == 0);   ib = (eb == maxe && fb == 0);
        na = (ea == maxe && fa != 0);   nb = (eb == maxe && fb != 0);
        qnan = (maxe << mw) | (one << (mw - 1));
        fl = 3'b000;
        if (na || nb) begin
            res = qnan;
        end else if ((za && ib) || (ia && zb)) begin
            res = qnan;
            fl  = 3'b100;
        end else if (ia || ib) begin
            res = sbit | (maxe << mw);
        end else if (za || zb) begin
            res = sbit;
        end else begin
            p = (fa | (one << mw)) * (fb | (one << mw));
            e = int'(ea) + int'(eb) - int'((one << (ew - 1)) - 1);
            if (p >= (one << (2 * mw + 1))) begin
                sh = mw + 1;
                e++;
            end else begin
                sh = mw;
            end
            q    = p >> sh;
            rem  = p & ((one << sh) - 1);
            half = one << (sh - 1);
            if (!rnd && (rem > half || (rem == half && q[0]))) q++;
            if (q == (one << (mw + 1))) begin
                q = q >> 1;
                e++;
            end
            if (e >= int'(maxe)) begin
                res = sbit | (maxe << mw);
                fl  = 3'b010;
            end else if (e <= 0) begin
                res = sbit;
                fl  = 3'b001;
            end else begin
                res = sbit | (u64'(e) << mw) | (q & fmask);
            end
        end
    endfunction

    function automatic u64 rand_operand(input int ew, input int mw);
        u64 one, e, f, s;
        int maxe, bias;
        one  = 1;
        maxe = (1 << ew) - 1;
        bias = (1 << (ew - 1)) - 1;
        s = u64'($urandom_range(0, 1));
        f = ((u64'($urandom) << 32) | u64'($urandom)) & ((one << mw) - 1);
        case ($urandom_range(0, 9))
            0:             e = 0;
            1: begin
                e = u64'(maxe);
                if ($urandom_range(0, 1) == 0) f = 0;
            end
            2, 3, 4, 5, 6: e = u64'(bias - 4 + int'($urandom_range(0, 8)));
            default:       e = u64'($urandom_range(0, maxe));
        endcase
        return (s << (ew + mw)) | (e << mw) | f;
    endfunction

    // One isolated operation; cycles counts rising edges from the accepting edge up to out_valid.
    task automatic do_op(input bit half, input u64 a, input u64 b, input bit rnd,
                         output u64 res, output logic [2:0] fl, output int cycles);
        @(negedge clk);
        if (half) begin
            bus16.x = a[15:0]; bus16.y = b[15:0]; bus16.rnd_mode = rnd;
            bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        end else begin
            bus32.x = a[31:0]; bus32.y = b[31:0]; bus32.rnd_mode = rnd;
            bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
        end
        @(posedge clk);
        cycles = 1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
        while (cycles < 20 && !(half ? bus16.out_valid : bus32.out_valid)) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        res = half ? u64'(bus16.result) : u64'(bus32.result);
        fl  = half ? bus16.flags : bus32.flags;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus32.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid32: got %b expected 0", bus32.out_valid); end
        tests_run++;
        if (bus32.result !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_result32: got %h expected 00000000", bus32.result); end
        tests_run++;
        if (bus32.flags !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags32: got %b expected 000", bus32.flags); end
        tests_run++;
        if (bus32.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready32: got %b expected 1", bus32.in_ready); end
        tests_run++;
        if (bus16.out_valid !== 1'b0 || bus16.result !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_half: got valid %b result %h expected 0 0000", bus16.out_valid, bus16.result);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t vt[$];
        u64 res;
        logic [2:0] fl;
        int cyc;
        vt.push_back(vec_t'{64'h3FC00000, 64'h40000000, 1'b0, 64'h40400000, 3'b000});
        vt.push_back(vec_t'{64'h3FC00000, 64'h3FC00000, 1'b0, 64'h40100000, 3'b000});
        vt.push_back(vec_t'{64'h3F800001, 64'h3FC00000, 1'b0, 64'h3FC00002, 3'b000});
        vt.push_back(vec_t'{64'h3F800001, 64'h3FC00000, 1'b1, 64'h3FC00001, 3'b000});
        vt.push_back(vec_t'{64'h7F000000, 64'h40000000, 1'b0, 64'h7F800000, 3'b010});
        vt.push_back(vec_t'{64'h00800000, 64'h3F000000, 1'b0, 64'h00000000, 3'b001});
        vt.push_back(vec_t'{64'h00000000, 64'h7F800000, 1'b0, 64'h7FC00000, 3'b100});
        vt.push_back(vec_t'{64'h7FA00000, 64'h3F800000, 1'b0, 64'h7FC00000, 3'b000});
        vt.push_back(vec_t'{64'h80000000, 64'h40000000, 1'b0, 64'h80000000, 3'b000});
        foreach (vt[i]) begin
            do_op(1'b0, vt[i].a, vt[i].b, vt[i].rnd, res, fl, cyc);
            tests_run++;
            if (cyc != 3) begin tests_failed++; $display("[TB] FAIL directed_latency[%0d]: got %0d expected 3", i, cyc); end
            tests_run++;
            if (res !== vt[i].res) begin tests_failed++; $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, res, vt[i].res); end
            tests_run++;
            if (fl !== vt[i].fl) begin tests_failed++; $display("[TB] FAIL directed_flags[%0d]: got %b expected %b", i, fl, vt[i].fl); end
        end
    endtask

    // Streams n operations on the 32-bit DUT; stall_mode 1 uses a fixed 4-cycle stall, 0 random ready/valid.
    task automatic stream(input int n, input bit stall_mode, input int budget);
        u64 qres[$];
        logic [2:0] qfl[$];
        u64 cur_a, cur_b, er, held;
        logic [2:0] ef;
        bit cur_r, have_held, want;
        int sent, got, c;
        sent = 0; got = 0; c = 0; have_held = 0;
        cur_a = rand_operand(8, 23); cur_b = rand_operand(8, 23); cur_r = 1'($urandom_range(0, 1));
        while (got < n && c < budget) begin
            @(negedge clk);
            want = stall_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus32.in_valid  = (sent < n) && want;
            bus32.x         = cur_a[31:0];
            bus32.y         = cur_b[31:0];
            bus32.rnd_mode  = cur_r;
            bus32.out_ready = stall_mode ? !(c >= 5 && c < 9) : ($urandom_range(0, 3) != 0);
            #1;
            if (stall_mode && !bus32.out_ready) begin
                tests_run++;
                if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_handshake c=%0d: got in_ready %b out_valid %b expected 0 1", c, bus32.in_ready, bus32.out_valid);
                end
                if (!have_held) begin
                    held = u64'(bus32.result);
                    have_held = 1'b1;
                end else begin
                    tests_run++;
                    if (u64'(bus32.result) !== held) begin
                        tests_failed++;
                        $display("[TB] FAIL stall_hold c=%0d: got %h expected %h", c, bus32.result, held);
                    end
                end
            end
            if (bus32.out_valid && bus32.out_ready) begin
                tests_run++;
                if (qres.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_extra_output: got %h expected no output", bus32.result);
                end else begin
                    er = qres.pop_front();
                    ef = qfl.pop_front();
                    if (u64'(bus32.result) !== er || bus32.flags !== ef) begin
                        tests_failed++;
                        $display("[TB] FAIL stream_result[%0d]: got %h/%b expected %h/%b", got, bus32.result, bus32.flags, er, ef);
                    end
                end
                got++;
            end
            if (bus32.in_valid && bus32.in_ready) begin
                ref_mul(cur_a, cur_b, cur_r, 8, 23, er, ef);
                qres.push_back(er);
                qfl.push_back(ef);
                sent++;
                cur_a = rand_operand(8, 23); cur_b = rand_operand(8, 23); cur_r = 1'($urandom_range(0, 1));
            end
            c++;
            @(posedge clk);
        end
        @(negedge clk);
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        tests_run++;
        if (got != n || sent != n) begin
            tests_failed++;
            $display("[TB] FAIL stream_count: got %0d results from %0d sent expected %0d", got, sent, n);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (bus32.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stream_drain: got out_valid %b expected 0", bus32.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        stream(8, 1'b1, 200);
    endtask

    task automatic test_random();
        stream(300, 1'b0, 5000);
    endtask

    task automatic test_reset_midstream();
        u64 res;
        logic [2:0] fl;
        int cyc;
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus32.x = 32'h3FC00000; bus32.y = 32'h40000000; bus32.rnd_mode = 1'b0;
            bus32.in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        bus32.in_valid = 1'b0;
        tests_run++;
        if (bus32.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_inflight: got %b expected 1", bus32.out_valid); end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus32.out_valid !== 1'b0 || bus32.result !== 32'h0 || bus32.flags !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL midreset_async: got valid %b result %h flags %b expected 0 00000000 000", bus32.out_valid, bus32.result, bus32.flags);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus32.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_flushed: got %b expected 0", bus32.out_valid); end
        do_op(1'b0, 64'h3FC00000, 64'h3FC00000, 1'b0, res, fl, cyc);
        tests_run++;
        if (cyc != 3 || res !== 64'h40100000) begin
            tests_failed++;
            $display("[TB] FAIL midreset_first_op: got %0d cycles %h expected 3 cycles 40100000", cyc, res);
        end
    endtask

    task automatic test_half();
        u64 res, a, b, er;
        logic [2:0] fl, ef;
        int cyc;
        bit r;
        do_op(1'b1, 64'h3E00, 64'h4000, 1'b0, res, fl, cyc);
        tests_run++;
        if (cyc != 3 || res !== 64'h4200 || fl !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL half_directed: got %0d cycles %h/%b expected 3 cycles 4200/000", cyc, res, fl);
        end
        for (int i = 0; i < 40; i++) begin
            a = rand_operand(5, 10);
            b = rand_operand(5, 10);
            r = 1'($urandom_range(0, 1));
            ref_mul(a, b, r, 5, 10, er, ef);
            do_op(1'b1, a, b, r, res, fl, cyc);
            tests_run++;
            if (res !== er || fl !== ef) begin
                tests_failed++;
                $display("[TB] FAIL half_random[%0d] %h*%h rnd%0d: got %h/%b expected %h/%b", i, a, b, r, res, fl, er, ef);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus32.in_valid = 1'b0; bus32.x = '0; bus32.y = '0; bus32.rnd_mode = 1'b0; bus32.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.x = '0; bus16.y = '0; bus16.rnd_mode = 1'b0; bus16.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        test_half();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
